// File: rtl/vde_pkg.sv
// Shared definitions for the VDE pixel path: tile map geometry (also used
// by the sprite emitter), the tile fetcher state encoding and the entry
// format carried from the tile fetcher to the sprite emitter.
package vde_pkg;

  // Tile map geometry: 80 x 60 tiles, 8 pixel rows per sprite -> 480 lines.
  localparam int VDE_MAP_WIDTH  = 80;
  localparam int VDE_MAP_HEIGHT = 60;
  localparam int VDE_SPRITE_H   = 8;
  localparam int VDE_MAP_AW     = 13;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // One tile on its way to the sprite emitter.
  typedef struct packed {
    logic [8:0] index;  // sprite index from the map word
    logic [3:0] row;    // pixel row inside the sprite
    logic       eol;    // last tile of a scanline
    logic       eof;    // last tile of the frame
  } tile_entry_t;

endpackage

// File: rtl/vde_skid_fifo2.sv
// Generic 2-entry valid/ready FIFO with a synchronous flush.
//
// Ports:
//   clk_i, rstn_i  clock, asynchronous active-low reset
//   flush_i        empties the FIFO; overrides push and pop in that cycle
//   push_i, din_i  write side (caller guarantees no push while full unless popping)
//   pop_i          read side; ignored while empty
//   valid_o        FIFO not empty
//   dout_o         head entry
//   count_o        occupancy 0..2
module vde_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop_i & (count_q != 2'd0) & ~flush_i;
  assign push_ok = push_i & ~flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) wr_ptr_d = ~wr_ptr_q;
      if (pop_ok)  rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        mem_q[gi] <= '0;
      end else if (push_ok && (wr_ptr_q == 1'(gi))) begin
        mem_q[gi] <= din_i;
      end
    end
  end

  assign valid_o = (count_q != 2'd0);
  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/vde_tile_fetcher.sv
// Tile fetcher: walks the tile map in scan order (cx fastest, then pixel
// row, then tile row), reads the sprite index of each tile from map memory
// and streams {sprite index, pixel row} to the sprite emitter.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   frame_start_i        pulse; (re)starts the walk at line 0, aborting any frame
//   map_mem_addr_o/en_o  map memory read request
//   map_mem_data_i       read data, one cycle after en; [8:0] = sprite index
//   sprite_valid_o/ready_i/data_o/row_o  tile stream
//   line_done_o          pulse when the last tile of a line is accepted
//   frame_done_o         pulse when the last tile of the frame is accepted
//   busy_o               high while a frame walk is in progress
module vde_tile_fetcher
  import vde_pkg::*;
#(
  parameter int MAP_WIDTH  = VDE_MAP_WIDTH,
  parameter int MAP_HEIGHT = VDE_MAP_HEIGHT,
  parameter int SPRITE_H   = VDE_SPRITE_H,
  parameter int MAP_AW     = VDE_MAP_AW
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              frame_start_i,
  output logic [MAP_AW-1:0] map_mem_addr_o,
  output logic              map_mem_en_o,
  input  logic [15:0]       map_mem_data_i,
  output logic              sprite_valid_o,
  input  logic              sprite_ready_i,
  output logic [8:0]        sprite_data_o,
  output logic [3:0]        sprite_row_o,
  output logic              line_done_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int CXW = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
  localparam int TRW = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1;

  fetch_state_t      state_q, state_d;
  logic [CXW-1:0]    cx_q, cx_d;
  logic [3:0]        prow_q, prow_d;
  logic [TRW-1:0]    trow_q, trow_d;
  logic [MAP_AW-1:0] row_base_q, row_base_d;

  // Tag of the read currently in flight (data arrives next cycle).
  logic              inflight_q, inflight_d;
  logic [3:0]        tag_row_q, tag_row_d;
  logic              tag_eol_q, tag_eol_d;
  logic              tag_eof_q, tag_eof_d;

  tile_entry_t       fifo_din;
  tile_entry_t       fifo_head;
  logic              fifo_valid;
  logic [1:0]        fifo_count;
  logic              fifo_push;
  logic              fifo_pop;

  logic              cx_last, prow_last, trow_last, frame_last;
  logic [2:0]        occupancy;
  logic              issue;

  // The sprite index lives in [8:0]; the upper map bits carry nothing here.
  logic              unused_map_bits;
  assign unused_map_bits = ^map_mem_data_i[15:9];

  assign cx_last    = (cx_q == CXW'(MAP_WIDTH - 1));
  assign prow_last  = (prow_q == 4'(SPRITE_H - 1));
  assign trow_last  = (trow_q == TRW'(MAP_HEIGHT - 1));
  assign frame_last = cx_last & prow_last & trow_last;

  // A restart flushes the buffer, so a pop in the same cycle is dropped.
  assign fifo_pop  = fifo_valid & sprite_ready_i & ~frame_start_i;
  assign fifo_push = inflight_q & ~frame_start_i;

  // Slots already claimed: buffered entries plus the read in flight. A pop
  // this cycle frees a slot in time for the next push, which is what lets
  // the stream sustain one tile per cycle without the buffer exceeding 2.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue     = (state_q == FETCH) & ~frame_start_i &
                     (occupancy < (3'd2 + {2'b00, fifo_pop}));

  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    prow_d     = prow_q;
    trow_d     = trow_q;
    row_base_d = row_base_q;
    inflight_d = 1'b0;
    tag_row_d  = tag_row_q;
    tag_eol_d  = tag_eol_q;
    tag_eof_d  = tag_eof_q;

    if (frame_start_i) begin
      // Restart from any state; the read in flight (if any) is discarded
      // by leaving inflight_d low.
      state_d    = FETCH;
      cx_d       = '0;
      prow_d     = '0;
      trow_d     = '0;
      row_base_d = '0;
    end else begin
      if (issue) begin
        inflight_d = 1'b1;
        tag_row_d  = prow_q;
        tag_eol_d  = cx_last;
        tag_eof_d  = frame_last;
        if (cx_last) begin
          cx_d = '0;
          if (prow_last) begin
            prow_d = '0;
            if (trow_last) begin
              trow_d     = '0;
              row_base_d = '0;
            end else begin
              trow_d     = trow_q + TRW'(1);
              row_base_d = row_base_q + MAP_AW'(MAP_WIDTH);
            end
          end else begin
            prow_d = prow_q + 4'd1;
          end
        end else begin
          cx_d = cx_q + CXW'(1);
        end
        if (frame_last) state_d = DRAIN;
      end
      // Popping the eof entry is necessarily the last one: nothing remains
      // buffered or in flight after it.
      if ((state_q == DRAIN) && fifo_pop && fifo_head.eof) state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      cx_q       <= '0;
      prow_q     <= '0;
      trow_q     <= '0;
      row_base_q <= '0;
      inflight_q <= 1'b0;
      tag_row_q  <= '0;
      tag_eol_q  <= 1'b0;
      tag_eof_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cx_q       <= cx_d;
      prow_q     <= prow_d;
      trow_q     <= trow_d;
      row_base_q <= row_base_d;
      inflight_q <= inflight_d;
      tag_row_q  <= tag_row_d;
      tag_eol_q  <= tag_eol_d;
      tag_eof_q  <= tag_eof_d;
    end
  end

  always_comb begin
    fifo_din       = '0;
    fifo_din.index = map_mem_data_i[8:0];
    fifo_din.row   = tag_row_q;
    fifo_din.eol   = tag_eol_q;
    fifo_din.eof   = tag_eof_q;
  end

  vde_skid_fifo2 #(
    .W($bits(tile_entry_t))
  ) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .flush_i (frame_start_i),
    .push_i  (fifo_push),
    .din_i   (fifo_din),
    .pop_i   (fifo_pop),
    .valid_o (fifo_valid),
    .dout_o  (fifo_head),
    .count_o (fifo_count)
  );

  assign map_mem_addr_o = row_base_q + MAP_AW'(cx_q);
  assign map_mem_en_o   = issue;
  assign sprite_valid_o = fifo_valid;
  assign sprite_data_o  = fifo_head.index;
  assign sprite_row_o   = fifo_head.row;
  assign line_done_o    = fifo_pop & fifo_head.eol;
  assign frame_done_o   = fifo_pop & fifo_head.eof;
  assign busy_o         = (state_q != IDLE);

endmodule
